// File: rtl/adc_pkg.sv
// Shared definitions for the ADC averaging path: state encoding, default
// widths and the accumulator sizing helper. Optional feature macro used by
// the averager files: ADC_AVG_MINMAX_EN (per-block min/max outputs).
package adc_pkg;

  localparam int ADC_DATA_WIDTH   = 16;
  localparam int ADC_LOG2_AVG_MAX = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

  // Sum of 2^log2_avg_max samples of data_width bits never exceeds this width.
  function automatic int acc_width(input int data_width, input int log2_avg_max);
    return data_width + log2_avg_max;
  endfunction

endpackage

// File: rtl/adc_sample_averager_if.sv
// Sample-in / result-out bus of the averager. With ADC_AVG_MINMAX_EN defined
// the bus also carries the per-block min/max values.
interface adc_sample_averager_if
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] sample_i;
  logic                  sample_valid_i;
  logic [DATA_WIDTH-1:0] avg_data_o;
  logic                  avg_valid_o;
  logic                  avg_ready_i;
`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_WIDTH-1:0] min_o;
  logic [DATA_WIDTH-1:0] max_o;
`endif

  // Averager side: consumes samples, produces results.
  modport master (
    input  sample_i,
    input  sample_valid_i,
    input  avg_ready_i,
    output avg_data_o,
    output avg_valid_o
`ifdef ADC_AVG_MINMAX_EN
    ,
    output min_o,
    output max_o
`endif
  );

  // Environment side: produces samples, consumes results.
  modport slave (
    output sample_i,
    output sample_valid_i,
    output avg_ready_i,
    input  avg_data_o,
    input  avg_valid_o
`ifdef ADC_AVG_MINMAX_EN
    ,
    input  min_o,
    input  max_o
`endif
  );

endinterface

// File: rtl/adc_minmax_tracker.sv
// Running min/max of the samples in one block. The load output includes the
// sample presented in the same cycle, so the final sample of a block counts.
// Only instantiated when ADC_AVG_MINMAX_EN is defined.
module adc_minmax_tracker
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH
) (
  input  logic                  clk_adc,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  update_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic [DATA_WIDTH-1:0] min_o,
  output logic [DATA_WIDTH-1:0] max_o
);

  logic [DATA_WIDTH-1:0] run_min_q, run_max_q;
  logic [DATA_WIDTH-1:0] run_min_d, run_max_d;
  logic [DATA_WIDTH-1:0] min_q, max_q;

  // Fold the current sample into the running extremes.
  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    if (update_i) begin
      if (sample_i < run_min_q) run_min_d = sample_i;
      if (sample_i > run_max_q) run_max_d = sample_i;
    end
  end

  // Running trackers restart at min=all-ones / max=0 at each block start.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      run_min_q <= '1;
      run_max_q <= '0;
    end else if (clear_i) begin
      run_min_q <= '1;
      run_max_q <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
    end
  end

  // Published values load alongside the averaged result.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else if (load_i) begin
      min_q <= run_min_d;
      max_q <= run_max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;

endmodule

// File: rtl/adc_sample_averager.sv
// Block averager: accumulates 2^N samples and presents the truncated mean on
// a valid/ready output register. Optional macro ADC_AVG_MINMAX_EN adds
// per-block min/max outputs on the bus.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH   = ADC_DATA_WIDTH,
  parameter int LOG2_AVG_MAX = ADC_LOG2_AVG_MAX
) (
  input  logic                  clk_adc,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [3:0]            avg_log2_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [LOG2_AVG_MAX:0] sample_cnt_o,
  adc_sample_averager_if.master bus
);

  localparam int         AW    = acc_width(DATA_WIDTH, LOG2_AVG_MAX);
  localparam int         CW    = LOG2_AVG_MAX + 1;
  localparam logic [3:0] N_MAX = 4'(LOG2_AVG_MAX);

  avg_state_t            state_q, state_d;
  logic [3:0]            n_q, n_clip;
  logic [AW-1:0]         acc_q, acc_d, acc_sum;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc, block_len;
  logic                  accum_run, sample_take, block_done, block_abort;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] avg_data_q;
  logic                  avg_valid_q, overrun_q;
  logic                  load_out, drop_out, consume;
  logic                  busy;

  assign n_clip      = (avg_log2_i > N_MAX) ? N_MAX : avg_log2_i;
  assign accum_run   = (state_q == ACCUM) && enable_i;
  assign block_abort = (state_q == ACCUM) && !enable_i;
  assign sample_take = accum_run && bus.sample_valid_i;
  assign cnt_inc     = cnt_q + CW'(1);
  assign block_len   = CW'(1) << n_q;
  assign block_done  = sample_take && (cnt_inc == block_len);
  assign acc_sum     = acc_q + AW'(bus.sample_i);
  assign result      = DATA_WIDTH'(acc_sum >> n_q);

  // A finished block either loads the output register or is dropped.
  assign consume  = avg_valid_q && bus.avg_ready_i;
  assign load_out = block_done && (!avg_valid_q || bus.avg_ready_i);
  assign drop_out = block_done && avg_valid_q && !bus.avg_ready_i;

  // State register.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: enable level alone moves between IDLE and ACCUM.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (enable_i) state_d = ACCUM;
    end else begin
      if (!enable_i) state_d = IDLE;
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == ACCUM);
  end

  // Accumulator and count: cleared outside ACCUM, on abort and at block end.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (!accum_run || block_done) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_take) begin
      acc_d = acc_sum;
      cnt_d = cnt_inc;
    end
  end

  // Accumulator, count and block exponent registers.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      n_q   <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (((state_q == IDLE) && enable_i) || block_done) n_q <= n_clip;
    end
  end

  // Output register: refill on empty or same-cycle consume, else hold.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
    end else if (load_out) begin
      avg_data_q  <= result;
      avg_valid_q <= 1'b1;
    end else if (consume) begin
      avg_valid_q <= 1'b0;
    end
  end

  // Sticky overrun; a new drop takes priority over clear.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst)           overrun_q <= 1'b0;
    else if (drop_out) overrun_q <= 1'b1;
    else if (clear_i)  overrun_q <= 1'b0;
  end

`ifdef ADC_AVG_MINMAX_EN
  adc_minmax_tracker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_minmax (
    .clk_adc (clk_adc),
    .rst     (rst),
    .clear_i (!accum_run || block_done || block_abort),
    .update_i(sample_take),
    .load_i  (load_out),
    .sample_i(bus.sample_i),
    .min_o   (bus.min_o),
    .max_o   (bus.max_o)
  );
`endif

  assign bus.avg_data_o  = avg_data_q;
  assign bus.avg_valid_o = avg_valid_q;
  assign busy_o          = busy;
  assign overrun_o       = overrun_q;
  assign sample_cnt_o    = cnt_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager: a block-level reference model
// pushes expected results; a monitor pops them on each output handshake.
// Define ADC_AVG_MINMAX_EN to also check min/max.
module tb_adc_sample_averager;
  import adc_pkg::*;

  typedef struct {
    int avg;
    int mn;
    int mx;
  } exp_t;

  logic       clk_adc = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [3:0] avg_log2_i = 4'd0;
  logic       busy_o, overrun_o;
  logic [8:0] sample_cnt_o;

  adc_sample_averager_if #(.DATA_WIDTH(16)) bus_if ();

  adc_sample_averager dut (
    .clk_adc     (clk_adc),
    .rst         (rst),
    .enable_i    (enable_i),
    .avg_log2_i  (avg_log2_i),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .sample_cnt_o(sample_cnt_o),
    .bus         (bus_if)
  );

  always #5 clk_adc = ~clk_adc;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state (block-level view)
  bit   m_running = 0;
  int   m_n = 0;
  int   m_block[$];
  bit   m_pending = 0;
  bit   m_overrun = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int clip_n(input int l2);
    return (l2 > ADC_LOG2_AVG_MAX) ? ADC_LOG2_AVG_MAX : l2;
  endfunction

  // Effect of one clock edge with the given inputs on the model.
  task automatic model_edge(input bit en, input bit vld, input int s,
                            input bit rdy, input bit clr, input int l2);
    bit     done;
    bit     drop;
    longint sum;
    exp_t   e;
    done = 0;
    drop = 0;
    sum  = 0;
    e.avg = 0; e.mn = 65535; e.mx = 0;
    if (!m_running) begin
      if (en) begin
        m_running = 1;
        m_n = clip_n(l2);
      end
    end else if (!en) begin
      m_running = 0;
      m_block.delete();
    end else if (vld) begin
      m_block.push_back(s);
      if (m_block.size() == (1 << m_n)) begin
        foreach (m_block[i]) begin
          sum += m_block[i];
          if (m_block[i] < e.mn) e.mn = m_block[i];
          if (m_block[i] > e.mx) e.mx = m_block[i];
        end
        e.avg = int'(sum / (longint'(1) << m_n));
        done = 1;
        m_block.delete();
        m_n = clip_n(l2);
      end
    end
    if (done) begin
      if (!m_pending || rdy) begin
        exp_q.push_back(e);
        m_pending = 1;
      end else begin
        drop = 1;
      end
    end else if (m_pending && rdy) begin
      m_pending = 0;
    end
    if (drop) m_overrun = 1;
    else if (clr) m_overrun = 0;
  endtask

  task automatic check_status();
    chk("busy", int'(busy_o), int'(m_running));
    chk("overrun", int'(overrun_o), int'(m_overrun));
    chk("sample_cnt", int'(sample_cnt_o), m_block.size());
    chk("avg_valid", int'(bus_if.avg_valid_o), int'(m_pending));
  endtask

  // One clock: check the state left by the previous edge, then drive.
  task automatic step(input bit en, input bit vld, input int s,
                      input bit rdy, input bit clr, input int l2);
    @(posedge clk_adc);
    #1;
    check_status();
    enable_i              = en;
    bus_if.sample_valid_i = vld;
    bus_if.sample_i       = 16'(s);
    bus_if.avg_ready_i    = rdy;
    clear_i               = clr;
    avg_log2_i            = 4'(l2);
    model_edge(en, vld, s, rdy, clr, l2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_avg_data"}, int'(bus_if.avg_data_o), 0);
    chk({tag, "_avg_valid"}, int'(bus_if.avg_valid_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_overrun"}, int'(overrun_o), 0);
    chk({tag, "_sample_cnt"}, int'(sample_cnt_o), 0);
`ifdef ADC_AVG_MINMAX_EN
    chk({tag, "_min"}, int'(bus_if.min_o), 0);
    chk({tag, "_max"}, int'(bus_if.max_o), 0);
`endif
  endtask

  // Run one full block of fixed samples at exponent l2, ready held high.
  task automatic block4(input int l2, input int a, input int b, input int c, input int d);
    step(1, 0, 0, 1, 0, l2);
    step(1, 1, a, 1, 0, l2);
    step(1, 1, b, 1, 0, l2);
    step(1, 1, c, 1, 0, l2);
    step(1, 1, d, 1, 0, l2);
    step(0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: each handshake pops the oldest expected result.
  always @(negedge clk_adc) begin
    if (!rst && bus_if.avg_valid_o && bus_if.avg_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", int'(bus_if.avg_data_o), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result avg=%0d expected=%0d", bus_if.avg_data_o, e.avg);
        chk("avg_data", int'(bus_if.avg_data_o), e.avg);
`ifdef ADC_AVG_MINMAX_EN
        chk("min", int'(bus_if.min_o), e.mn);
        chk("max", int'(bus_if.max_o), e.mx);
`endif
      end
    end
  end

  initial begin
    bus_if.sample_i       = '0;
    bus_if.sample_valid_i = 1'b0;
    bus_if.avg_ready_i    = 1'b0;
    repeat (2) @(posedge clk_adc);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // N=2: 10,20,30,41 -> 25
    block4(2, 10, 20, 30, 41);
    idle(2);

    // Min/max pattern: 3,9,1,4 -> avg 4, min 1, max 9
    block4(2, 3, 9, 1, 4);
    idle(2);

    // N=8, 256 full-scale samples back-to-back
    step(1, 0, 0, 1, 0, 8);
    for (int i = 0; i < 256; i++) step(1, 1, 16'hFFFF, 1, 0, 8);
    idle(3);

    // N=0, ready low: 5 kept, 7 dropped, overrun; then clear, then consume
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);

    // N=3 abort after 5 samples (sample in the abort cycle is discarded)
    step(1, 0, 0, 1, 0, 3);
    for (int i = 0; i < 5; i++) step(1, 1, 1000 + i, 1, 0, 3);
    step(0, 1, 999, 1, 0, 3);
    idle(2);
    step(1, 0, 0, 1, 0, 3);
    for (int i = 0; i < 8; i++) step(1, 1, 100, 1, 0, 3);
    idle(2);

    // Exponent 12 clips to 8: result after exactly 256 random samples
    step(1, 0, 0, 1, 0, 12);
    for (int i = 0; i < 256; i++) step(1, 1, int'($urandom_range(0, 65535)), 1, 0, 12);
    idle(2);

    // Randomized traffic: gaps, ready stalls, clears, mid-block N changes
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 60) != 0, ($urandom % 4) != 0, int'($urandom_range(0, 65535)),
           ($urandom % 3) != 0, ($urandom % 12) == 0, int'($urandom_range(0, 4)));
    end

    // Drain outstanding results within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_pending", exp_q.size(), 0);

    // Reset mid-block with a result pending
    idle(2);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 3, 0, 0, 1);
    step(1, 1, 5, 0, 0, 1);
    step(1, 1, 9, 0, 0, 1);
    @(posedge clk_adc);
    #3;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    enable_i = 1'b0;
    bus_if.sample_valid_i = 1'b0;
    bus_if.avg_ready_i = 1'b1;
    clear_i = 1'b0;
    m_running = 0; m_n = 0; m_block.delete();
    m_pending = 0; m_overrun = 0; exp_q.delete();
    #2;
    rst = 1'b0;

    // Operation resumes after reset
    block4(2, 10, 20, 30, 41);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_final", exp_q.size(), 0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
